// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with run-time frame format,
// 3-sample majority voting, error flags, valid/ack handshake and RTS.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a synchronised falling edge on Rx
// S_START    | checking the start bit at mid-bit (majority 1 = false start)
// S_DATA     | shifting in the latched number of data bits, LSB first
// S_PARITY   | capturing and checking the parity bit
// S_STOP1    | sampling the first stop bit
// S_STOP2    | sampling the second stop bit
// S_COMPLETE | one cycle: publish data/errors or flag overrun
// S_BRK_WAIT | after a break, wait for Rx high for one full bit time
module uart_rx_cfg #(
  parameter int SYSCLK_RATE   = 100000000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     SysClk,
  input  logic                     Rst,
  input  logic                     Enable,
  input  logic                     Rx,
  input  logic [3:0]               Cfg_Data_Bits,
  input  logic [1:0]               Cfg_Parity,
  input  logic                     Cfg_Stop_Bits,
  output logic [MAX_DATA_BITS-1:0] Data_Out,
  output logic                     Data_Rdy,
  input  logic                     Data_Ack,
  output logic [3:0]               Rx_Error,
  output logic                     RTS,
  output logic                     Rx_Busy
);

  localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int HW      = $clog2(OVERSAMPLE + 1);
  localparam logic [SW-1:0] IDX_S0   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] IDX_S1   = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] IDX_S2   = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    MAXB     = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_COMPLETE, S_BRK_WAIT
  } state_t;

  state_t                   r_state, w_state_next;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_rx_d;
  logic [DW-1:0]            r_div_cnt;
  logic [SW-1:0]            r_smp;
  logic [HW-1:0]            r_hi_cnt;
  logic                     r_armed;
  logic                     r_s0, r_s1;
  logic [3:0]               r_cfg_bits;
  logic [1:0]               r_cfg_par;
  logic                     r_cfg_stop2;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic [3:0]               r_bit_cnt;
  logic                     r_par_acc, r_par_err, r_frm_err, r_all_zero;
  logic [MAX_DATA_BITS-1:0] r_data_out;
  logic                     r_data_rdy;
  logic [3:0]               r_rx_err;
  logic                     r_rts, r_busy;

  logic                     w_rx, w_start, w_tick, w_stb, w_bit, w_line_idle;
  logic [3:0]               w_cfg_bits;
  logic [MAX_DATA_BITS-1:0] w_data;

  assign w_rx        = r_sync[SYNC_STAGES-1];
  // r_armed blocks edges left over from a frame cut short by reset/disable
  assign w_start     = (r_state == S_IDLE) && Enable && r_armed && r_rx_d && !w_rx;
  assign w_tick      = (r_div_cnt == '0);
  assign w_stb       = w_tick && (r_smp == IDX_S2);
  assign w_bit       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_line_idle = (r_hi_cnt == '0);
  assign w_cfg_bits  = (Cfg_Data_Bits < 4'd5) ? 4'd5 :
                       (Cfg_Data_Bits > MAXB) ? MAXB : Cfg_Data_Bits;
  // bits arrive at the MSB end; shift down to right-justify the field
  assign w_data      = r_shift >> (MAXB - r_cfg_bits);

  assign Data_Out = r_data_out;
  assign Data_Rdy = r_data_rdy;
  assign Rx_Error = r_rx_err;
  assign RTS      = r_rts;
  assign Rx_Busy  = r_busy;

  // Rx synchroniser and one-cycle delayed copy for falling-edge detection
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx};
      r_rx_d <= w_rx;
    end
  end

  // Sample tick down-counter and in-bit tick index, realigned on start edge
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_div_cnt <= DW'(DIV - 1);
      r_smp     <= '0;
    end else if (w_start) begin
      r_div_cnt <= DW'(DIV - 1);
      r_smp     <= SW'(1);
    end else if (w_tick) begin
      r_div_cnt <= DW'(DIV - 1);
      r_smp     <= (r_smp == IDX_LAST) ? '0 : r_smp + SW'(1);
    end else begin
      r_div_cnt <= r_div_cnt - DW'(1);
    end
  end

  // Line-idle timer (one bit of continuous high) and receive arming
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_hi_cnt <= HW'(OVERSAMPLE);
      r_armed  <= 1'b0;
    end else begin
      if (!w_rx)                         r_hi_cnt <= HW'(OVERSAMPLE);
      else if (w_tick && !w_line_idle)   r_hi_cnt <= r_hi_cnt - HW'(1);
      if (!Enable)                       r_armed <= 1'b0;
      else if (w_line_idle)              r_armed <= 1'b1;
    end
  end

  // First two of the three majority samples around mid-bit
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (r_smp == IDX_S0) r_s0 <= w_rx;
      if (r_smp == IDX_S1) r_s1 <= w_rx;
    end
  end

  // State register
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; every bit decision is taken on the mid-bit strobe
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_state_next = S_START;
      S_START:    if (w_stb) w_state_next = w_bit ? S_IDLE : S_DATA;
      S_DATA:     if (w_stb && (r_bit_cnt == r_cfg_bits - 4'd1))
                    w_state_next = (r_cfg_par != 2'b00) ? S_PARITY : S_STOP1;
      S_PARITY:   if (w_stb) w_state_next = S_STOP1;
      S_STOP1:    if (w_stb) w_state_next = r_cfg_stop2 ? S_STOP2 : S_COMPLETE;
      S_STOP2:    if (w_stb) w_state_next = S_COMPLETE;
      S_COMPLETE: w_state_next = r_all_zero ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (w_line_idle) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
    if (!Enable) w_state_next = S_IDLE;
  end

  // Frame datapath: config latch, shift register, parity/frame/break tracking
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_cfg_bits  <= 4'd8;
      r_cfg_par   <= 2'b00;
      r_cfg_stop2 <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_acc   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_all_zero  <= 1'b0;
    end else if (w_start) begin
      r_cfg_bits  <= w_cfg_bits;
      r_cfg_par   <= (Cfg_Parity == 2'b11) ? 2'b00 : Cfg_Parity;
      r_cfg_stop2 <= Cfg_Stop_Bits;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_acc   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_all_zero  <= 1'b1;
    end else if (w_stb) begin
      case (r_state)
        S_DATA: begin
          r_shift   <= {w_bit, r_shift[MAX_DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_par_acc <= r_par_acc ^ w_bit;
          if (w_bit) r_all_zero <= 1'b0;
        end
        S_PARITY: begin
          r_par_err <= (r_cfg_par == 2'b01) ? (r_par_acc ^ w_bit) : ~(r_par_acc ^ w_bit);
          if (w_bit) r_all_zero <= 1'b0;
        end
        S_STOP1: begin
          if (!w_bit) r_frm_err  <= 1'b1;
          else        r_all_zero <= 1'b0;
        end
        S_STOP2: if (!w_bit) r_frm_err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output registers: publish on COMPLETE, overrun keeps old data, ack clears
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      r_data_out <= '0;
      r_data_rdy <= 1'b0;
      r_rx_err   <= 4'b0000;
      r_rts      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (r_state == S_COMPLETE) begin
        if (r_data_rdy && !Data_Ack) begin
          r_rx_err <= 4'b1000;
        end else begin
          r_data_out <= w_data;
          r_rx_err   <= {1'b0, r_frm_err & ~r_all_zero, r_par_err & ~r_all_zero, r_all_zero};
          r_data_rdy <= 1'b1;
        end
      end else if (Data_Ack) begin
        r_data_rdy <= 1'b0;
      end
      r_rts  <= ~r_data_rdy;
      r_busy <= (w_state_next != S_IDLE) && (w_state_next != S_BRK_WAIT);
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg at DIV=10, 160 clocks per bit.
module tb_uart_rx_cfg;

  localparam int BIT_CYC = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rx;
  logic [3:0] cfg_bits;
  logic [1:0] cfg_par;
  logic       cfg_stop;
  logic [8:0] data_out;
  logic       data_rdy;
  logic       data_ack;
  logic [3:0] rx_error;
  logic       rts;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  uart_rx_cfg #(
    .SYSCLK_RATE(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .MAX_DATA_BITS(9), .SYNC_STAGES(2)
  ) dut (
    .SysClk(clk), .Rst(rst_n), .Enable(enable), .Rx(rx),
    .Cfg_Data_Bits(cfg_bits), .Cfg_Parity(cfg_par), .Cfg_Stop_Bits(cfg_stop),
    .Data_Out(data_out), .Data_Rdy(data_rdy), .Data_Ack(data_ack),
    .Rx_Error(rx_error), .RTS(rts), .Rx_Busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // par: 0 none, 1 even, 2 odd. Called on a negedge; returns after the last stop bit.
  task automatic send_frame(input logic [8:0] data, input int nbits, input int par,
                            input bit par_inv, input bit two_stop, input bit stop2_val);
    logic p;
    p = 1'b0;
    rx = 1'b0;
    wait_neg(BIT_CYC);
    for (int i = 0; i < nbits; i++) begin
      rx = data[i];
      p  = p ^ data[i];
      wait_neg(BIT_CYC);
    end
    if (par != 0) begin
      rx = ((par == 1) ? p : ~p) ^ par_inv;
      wait_neg(BIT_CYC);
    end
    rx = 1'b1;
    wait_neg(BIT_CYC);
    if (two_stop) begin
      rx = stop2_val;
      wait_neg(BIT_CYC);
      rx = 1'b1;
    end
  endtask

  task automatic ack_and_idle(input int idle);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    rx = 1'b1;
    wait_neg(idle);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    rx       = 1'b1;
    cfg_bits = 4'd8;
    cfg_par  = 2'b00;
    cfg_stop = 1'b0;
    data_ack = 1'b0;
    wait_neg(4);
    check("rst_data",  16'(data_out), 16'h000);
    check("rst_rdy",   16'(data_rdy), 16'h0);
    check("rst_err",   16'(rx_error), 16'h0);
    check("rst_rts",   16'(rts),      16'h1);
    check("rst_busy",  16'(rx_busy),  16'h0);
    rst_n = 1'b1;
    wait_neg(400);

    // 8N1 0xA5 with exact Data_Rdy timing
    fork
      send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (1533) @(posedge clk);
        @(negedge clk);
        check("a5_rdy_early", 16'(data_rdy), 16'h0);
        @(negedge clk);
        check("a5_rdy_rise", 16'(data_rdy), 16'h1);
      end
    join
    check("a5_data", 16'(data_out), 16'h0A5);
    check("a5_err",  16'(rx_error), 16'h0);
    check("a5_rts",  16'(rts),      16'h0);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("a5_ack_clr", 16'(data_rdy), 16'h0);
    @(negedge clk);
    check("a5_rts_back", 16'(rts), 16'h1);
    wait_neg(200);

    // 7 data bits, odd parity, parity bit inverted
    cfg_bits = 4'd7;
    cfg_par  = 2'b10;
    cfg_stop = 1'b0;
    send_frame(9'h055, 7, 2, 1'b1, 1'b0, 1'b1);
    check("par_data", 16'(data_out), 16'h055);
    check("par_err",  16'(rx_error), 16'h2);
    ack_and_idle(200);

    // 8E2 with second stop bit low; config disturbed mid-frame
    cfg_bits = 4'd8;
    cfg_par  = 2'b01;
    cfg_stop = 1'b1;
    fork
      send_frame(9'h03C, 8, 1, 1'b0, 1'b1, 1'b0);
      begin
        wait_neg(400);
        cfg_bits = 4'd5;
        cfg_par  = 2'b00;
        cfg_stop = 1'b0;
      end
    join
    check("frm_data", 16'(data_out), 16'h03C);
    check("frm_err",  16'(rx_error), 16'h4);
    ack_and_idle(200);

    // Break: 20 bit times low, 8N1
    cfg_bits = 4'd8;
    cfg_par  = 2'b00;
    cfg_stop = 1'b0;
    rx = 1'b0;
    wait_neg(20 * BIT_CYC);
    check("brk_rdy",  16'(data_rdy), 16'h1);
    check("brk_err",  16'(rx_error), 16'h1);
    check("brk_data", 16'(data_out), 16'h000);
    check("brk_busy", 16'(rx_busy),  16'h0);
    ack_and_idle(300);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1'b1);
    check("postbrk_data", 16'(data_out), 16'h03C);
    check("postbrk_err",  16'(rx_error), 16'h0);
    ack_and_idle(200);

    // Overrun, then ack coinciding with COMPLETE of a third frame
    send_frame(9'h011, 8, 0, 1'b0, 1'b0, 1'b1);
    send_frame(9'h022, 8, 0, 1'b0, 1'b0, 1'b1);
    check("ovr_data", 16'(data_out), 16'h011);
    check("ovr_err",  16'(rx_error), 16'h8);
    check("ovr_rts",  16'(rts),      16'h0);
    check("ovr_rdy",  16'(data_rdy), 16'h1);
    fork
      send_frame(9'h033, 8, 0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (1533) @(posedge clk);
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    check("coack_data", 16'(data_out), 16'h033);
    check("coack_err",  16'(rx_error), 16'h0);
    check("coack_rdy",  16'(data_rdy), 16'h1);
    ack_and_idle(200);

    // False start: 3 sample ticks low
    rx = 1'b0;
    wait_neg(30);
    check("fs_busy_hi", 16'(rx_busy), 16'h1);
    rx = 1'b1;
    wait_neg(200);
    check("fs_busy_lo", 16'(rx_busy),  16'h0);
    check("fs_rdy",     16'(data_rdy), 16'h0);
    wait_neg(200);

    // Reset mid-frame, then a clean frame
    send_frame(9'h077, 8, 0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_data", 16'(data_out), 16'h077);
    fork
      send_frame(9'h000, 8, 0, 1'b0, 1'b0, 1'b1);
      begin
        wait_neg(700);
        rst_n = 1'b0;
        wait_neg(2);
        check("mrst_data", 16'(data_out), 16'h000);
        check("mrst_rdy",  16'(data_rdy), 16'h0);
        check("mrst_err",  16'(rx_error), 16'h0);
        check("mrst_rts",  16'(rts),      16'h1);
        check("mrst_busy", 16'(rx_busy),  16'h0);
        rst_n = 1'b1;
        wait_neg(300);
        check("mrst_ignored", 16'(rx_busy), 16'h0);
      end
    join
    wait_neg(400);
    send_frame(9'h05A, 8, 0, 1'b0, 1'b0, 1'b1);
    check("clean_data", 16'(data_out), 16'h05A);
    check("clean_err",  16'(rx_error), 16'h0);
    check("clean_rdy",  16'(data_rdy), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Next-generation UART receiver: oversampled, 3-sample majority-voted receive front end.
- Frame format (data length, parity mode, stop bits) is selected at run time within parametrised limits.
- Detects break, parity, frame and overrun errors; presents each frame with a valid/ack handshake and RTS flow control.
- Sits between the Rx pin and the receive FIFO / BIST mux, in place of the fixed-format receiver.

Parameters:
- SYSCLK_RATE, 100000000, SysClk frequency in Hz.
- BAUD_RATE, 9600, line rate in baud.
- OVERSAMPLE, 16, sample ticks per bit; even, >=8.
- MAX_DATA_BITS, 9, widest supported data field; 5..9.
- SYNC_STAGES, 2, Rx synchroniser depth; >=2.

Ports:
- SysClk  in  1  system clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Enable  in  1  receiver enable.
- Rx  in  1  serial line, asynchronous, idle high.
- Cfg_Data_Bits  in  4  data bits per frame, 5..MAX_DATA_BITS.
- Cfg_Parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- Cfg_Stop_Bits  in  1  0 = one stop bit, 1 = two stop bits.
- Data_Out  out  MAX_DATA_BITS  received data, LSB-first on the line, right-justified, unused MSBs zero.
- Data_Rdy  out  1  Data_Out/Rx_Error valid.
- Data_Ack  in  1  consumer has taken the data.
- Rx_Error  out  4  [0] break, [1] parity, [2] frame, [3] overrun.
- RTS  out  1  high when the receiver can accept a frame.
- Rx_Busy  out  1  a frame is in progress.

Behaviour:
- Reset (Rst low, asynchronous): state IDLE; Data_Out=0, Data_Rdy=0, Rx_Error=0, Rx_Busy=0, RTS=1; synchroniser flops set to 1.
- Tick generator: DIV = SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE), integer truncation, minimum 1.
  - One-cycle tick every DIV SysClk cycles.
  - Counter restarts on start-edge detection so sample phase aligns to the edge.
- Rx passes through SYNC_STAGES flops before any use.
- Bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
- Configuration is latched at start-edge detection; changes mid-frame have no effect. Cfg_Data_Bits is clamped to the range 5..MAX_DATA_BITS.
- FSM:
  - IDLE: a synchronised falling edge on Rx enters START; Rx_Busy goes 1 on the next cycle.
  - START: majority 1 means a false start, return to IDLE with no output. Otherwise enter DATA.
  - DATA: shift in the latched number of bits, LSB first; then go to PARITY if parity is enabled, else STOP1.
  - PARITY: capture the bit; even mode requires XOR(data, parity)=0, odd mode requires it to equal 1.
  - STOP1: if two stop bits, go to STOP2; else COMPLETE.
  - STOP2: go to COMPLETE.
  - COMPLETE: one cycle; update outputs; next state IDLE, or BRK_WAIT on break.
  - BRK_WAIT: stay until synchronised Rx=1 for one full bit time, then IDLE.
- Error definitions, evaluated at COMPLETE:
  - Break: all data bits, the parity bit (if present) and stop bit 1 sampled 0. Sets [0] only; [1] and [2] are suppressed.
  - Parity: parity mismatch, no break.
  - Frame: any stop bit sampled 0, no break.
  - Overrun: Data_Rdy still 1 at COMPLETE with no Data_Ack in the same cycle. Data_Out is kept (the new frame is dropped) and Rx_Error becomes 4'b1000.
- Output timing: Data_Out, Rx_Error and Data_Rdy update on the SysClk edge leaving COMPLETE, i.e. 1 cycle after the last stop-bit sample tick. Rx_Error holds until the next COMPLETE.
- Handshake: Data_Ack while Data_Rdy=1 clears Data_Rdy next cycle. Data_Ack while Data_Rdy=0 is ignored.
- Ack and COMPLETE in the same cycle: new data loads, Data_Rdy stays 1, no overrun.
- RTS = registered !Data_Rdy.
- Enable low: FSM forced to IDLE within 1 cycle; a partial frame is discarded; Data_Rdy/Data_Out/Rx_Error are retained.
- Reset mid-frame: immediate return to reset state; the remainder of the frame is ignored until Rx has been idle high and a new falling edge arrives.

Test Plan (SYSCLK_RATE=1600000, BAUD_RATE=10000, OVERSAMPLE=16 → DIV=10, 160 cycles/bit):
- 8N1 frame 0xA5 → Data_Rdy rises 1 cycle after stop-bit sample; Data_Out=9'h0A5, Rx_Error=4'b0000; Data_Ack clears it next cycle and RTS returns to 1.
- 7 data bits, odd parity, 0x55 sent with inverted parity bit → Data_Out=9'h055, Rx_Error=4'b0010.
- 8E2 frame 0x3C with second stop bit 0 → Data_Out=9'h03C, Rx_Error=4'b0100.
- Rx held low for 20 bit times, 8N1 → Rx_Error=4'b0001, Data_Out=0, FSM held in BRK_WAIT; after Rx high, frame 0x3C is received with Rx_Error=0.
- Frames 0x11 then 0x22, no Data_Ack → Data_Out=9'h011, Rx_Error=4'b1000, RTS=0. Ack coinciding with a third frame 0x33 → Data_Out=9'h033, no overrun.
- Rx low for only 3 sample ticks → no Data_Rdy, Rx_Busy back to 0. Rst pulsed low mid-frame → all outputs at reset values; the next clean frame 0x5A is received correctly.
